// File: rtl/nx1_pkg.sv
// Shared constants, command-word layout and FSM states for the Neuromorphic_X1
// command sequencer.
package nx1_pkg;
  localparam logic [31:0] NX1_ADDR  = 32'h3000_000C;
  localparam logic [31:0] NX1_EMPTY = 32'hDEAD_C0DE;
  localparam logic [1:0]  MODE_PROG = 2'b11;
  localparam logic [1:0]  MODE_READ = 2'b01;

  localparam int CMD_MODE_LSB = 30;
  localparam int CMD_ROW_LSB  = 25;
  localparam int CMD_COL_LSB  = 20;
  localparam int CMD_DATA_LSB = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_GAP} nx1_state_e;

  // Bits [19:8] stay zero; read commands carry no data byte.
  function automatic logic [31:0] nx1_cmd_word(input logic op, input logic [4:0] row,
                                               input logic [4:0] col, input logic [7:0] data);
    logic [31:0] w;
    w = '0;
    w[CMD_MODE_LSB +: 2] = op ? MODE_PROG : MODE_READ;
    w[CMD_ROW_LSB  +: 5] = row;
    w[CMD_COL_LSB  +: 5] = col;
    w[CMD_DATA_LSB +: 8] = op ? data : 8'h00;
    return w;
  endfunction
endpackage

// File: rtl/nx1_tag_fifo.sv
// Circular FIFO of {row, col} tags for read commands still awaiting a result.
module nx1_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 10
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [5:0]   o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [4:0]   r_wp, r_rp;
  logic [5:0]   r_cnt;

  function automatic logic [4:0] nxt(input logic [4:0] p);
    return (p == 5'(DEPTH-1)) ? 5'd0 : p + 5'd1;
  endfunction

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= nxt(r_wp);
      end
      if (i_pop) r_rp <= nxt(r_rp);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 6'd1;
        2'b01:   r_cnt <= r_cnt - 6'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/nx1_cmd_sequencer.sv
// Wishbone master that issues program/read commands to the NX1 macro and polls
// its result register, returning tagged results in issue order.
module nx1_cmd_sequencer import nx1_pkg::*; #(
  parameter int MAX_PEND = 32,
  parameter int ACK_TO   = 1024,
  parameter int POLL_GAP = 8,
  parameter int POLL_MAX = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [4:0]  req_row,
  input  logic [4:0]  req_col,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic        rsp_bit,
  output logic [4:0]  rsp_row,
  output logic [4:0]  rsp_col,
  output logic        rsp_err,
  output logic [5:0]  pending,
  output logic        busy,
  output logic        err_ack,
  input  logic        clr_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam int AW = $clog2(ACK_TO + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  nx1_state_e r_state, w_next;
  logic          r_rr, r_cyc, r_we, r_is_read, r_err_ack;
  logic [31:0]   r_dat;
  logic [9:0]    r_tag;
  logic [AW-1:0] r_ack_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [PW-1:0] r_empty_cnt;
  logic          r_rsp_valid, r_rsp_bit, r_rsp_err;
  logic [4:0]    r_rsp_row, r_rsp_col;

  logic [5:0] w_pending;
  logic [9:0] w_head;
  logic w_full, w_poll_first, w_accept, w_bus, w_to, w_empty, w_lost, w_push, w_pop;

  assign w_full       = (w_pending == 6'(MAX_PEND));
  assign w_poll_first = (|w_pending) & (r_rr | w_full);
  assign req_ready    = wb_rst_ni & (r_state == ST_IDLE) & !w_poll_first & !(!req_op & w_full);
  assign w_accept     = req_valid & req_ready;
  assign w_bus        = (r_state == ST_WR) | (r_state == ST_RD);
  assign w_to         = w_bus & !wbm_ack_i & (r_ack_cnt == AW'(ACK_TO - 1));
  assign w_empty      = (wbm_dat_i == NX1_EMPTY);
  assign w_lost       = w_empty & (r_empty_cnt == PW'(POLL_MAX - 1));
  assign w_push       = (r_state == ST_WR) & wbm_ack_i & r_is_read;
  assign w_pop        = (r_state == ST_RD) & wbm_ack_i & (!w_empty | w_lost);

  nx1_tag_fifo #(.DEPTH(MAX_PEND), .W(10)) u_tags (
    .gclk(wb_clk_i), .grst_n(wb_rst_ni), .i_push(w_push), .i_pop(w_pop),
    .i_din(r_tag), .o_dout(w_head), .o_count(w_pending)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WR;
               else if (|w_pending) w_next = ST_RD;
      ST_WR:   if (wbm_ack_i || w_to) w_next = ST_IDLE;
      ST_RD:   if (wbm_ack_i) w_next = w_empty ? ST_GAP : ST_IDLE;
               else if (w_to) w_next = ST_IDLE;
      ST_GAP:  if (r_gap_cnt == GW'(POLL_GAP - 1)) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus strobes are registered from the next state, so an ack always yields an idle cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rr <= 1'b0; r_cyc <= 1'b0; r_we <= 1'b0; r_is_read <= 1'b0; r_err_ack <= 1'b0;
      r_dat <= '0; r_tag <= '0; r_ack_cnt <= '0; r_gap_cnt <= '0; r_empty_cnt <= '0;
      r_rsp_valid <= 1'b0; r_rsp_bit <= 1'b0; r_rsp_err <= 1'b0;
      r_rsp_row <= '0; r_rsp_col <= '0;
    end else begin
      r_cyc       <= (w_next == ST_WR) | (w_next == ST_RD);
      r_we        <= (w_next == ST_WR);
      r_rsp_valid <= 1'b0;
      r_ack_cnt   <= (w_bus && r_state == w_next) ? r_ack_cnt + AW'(1) : '0;
      r_gap_cnt   <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
      if (w_accept) begin
        r_dat     <= nx1_cmd_word(req_op, req_row, req_col, req_data);
        r_is_read <= !req_op;
        r_tag     <= {req_row, req_col};
        r_rr      <= 1'b1;
      end else if (r_state == ST_IDLE && |w_pending) begin
        r_rr <= 1'b0;
      end
      if (w_to)         r_err_ack <= 1'b1;
      else if (clr_err) r_err_ack <= 1'b0;
      if (r_state == ST_RD && wbm_ack_i) begin
        if (w_pop) begin
          r_rsp_valid <= 1'b1;
          r_rsp_bit   <= w_empty ? 1'b0 : wbm_dat_i[0];
          r_rsp_err   <= w_empty;
          r_rsp_row   <= w_head[9:5];
          r_rsp_col   <= w_head[4:0];
          r_empty_cnt <= '0;
        end else begin
          r_empty_cnt <= r_empty_cnt + PW'(1);
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_bit   = r_rsp_bit;
  assign rsp_row   = r_rsp_row;
  assign rsp_col   = r_rsp_col;
  assign rsp_err   = r_rsp_err;
  assign pending   = w_pending;
  assign busy      = (r_state != ST_IDLE) | (|w_pending);
  assign err_ack   = r_err_ack;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = NX1_ADDR;
  assign wbm_dat_o = r_dat;
endmodule
